serial_word_collector: RTL

Deserializer stage sitting directly downstream of the lab's gate-level D flip-flop: it consumes the registered single-bit Q stream and assembles it into parallel words. Bits are shifted in MSB-first under a valid/ready handshake. Each completed word is held on a parallel output under a second valid/ready handshake until the consumer accepts it. Used as the serial-to-parallel front end for the later register-file and display labs.

---
 rtl/serial_word_collector.sv | 64 ++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector: MSB-first serial-to-parallel word collector with valid/ready handshakes.
// Define PARITY_EN to append one even-parity bit to each frame.
module serial_word_collector #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             serialIn,
    input  logic             serialValid,
    output logic             serialReady,
    output logic [WIDTH-1:0] parallelOut,
    output logic             wordValid,
    input  logic             wordReady,
    output logic             parityError,
    output logic [4:0]       bitCount
);
`ifdef PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam bit PARITY = 1'b1;
`else
    localparam int FRAME = WIDTH;
    localparam bit PARITY = 1'b0;
`endif
    localparam logic [4:0] LAST = 5'(FRAME - 1);
    typedef enum logic {COLLECT, HOLD} stateType;
    stateType state;
    logic [WIDTH-1:0] shift;
    assign serialReady = reset_ && state == COLLECT;
    assign wordValid = state == HOLD;
    // With parity the final bit is the check bit, so the word is already complete in shift.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= COLLECT;
            shift <= '0;
            bitCount <= '0;
            parallelOut <= '0;
        end else if (state == HOLD) begin
            if (wordReady) state <= COLLECT;
        end else if (serialValid) begin
            shift <= {shift[WIDTH-2:0], serialIn};
            if (bitCount == LAST) begin
                bitCount <= '0;
                state <= HOLD;
                parallelOut <= PARITY ? shift : {shift[WIDTH-2:0], serialIn};
            end else begin
                bitCount <= bitCount + 5'd1;
            end
        end
    end
`ifdef PARITY_EN
    logic parAcc;
    always_ff @(posedge clock) begin
        if (!reset_) begin
            parAcc <= 1'b0;
            parityError <= 1'b0;
        end else if (state == COLLECT && serialValid) begin
            parAcc <= (bitCount == LAST) ? 1'b0 : parAcc ^ serialIn;
            if (bitCount == LAST) parityError <= parAcc ^ serialIn;
        end
    end
`else
    assign parityError = 1'b0;
`endif
endmodule
